// File: rtl/spi_master_if.sv
// Host and SPI pin bundle for spi_master; the master modport is the controller's view.
interface spi_master_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  Start;
    logic [1:0]            SalveSelect;
    logic [DATA_WIDTH-1:0] MasterDataToSalve;
    logic [DATA_WIDTH-1:0] MasterDataReceived;
    logic                  Sclk;
    logic [0:2]            Cs;
    logic                  Mosi;
    logic                  Miso;

    modport master (
        input  Start, SalveSelect, MasterDataToSalve, Miso,
        output MasterDataReceived, Sclk, Cs, Mosi
    );

    modport slave (
        output Start, SalveSelect, MasterDataToSalve, Miso,
        input  MasterDataReceived, Sclk, Cs, Mosi
    );
endinterface

// File: rtl/spi_master.sv
// Single-master SPI controller: one full-duplex word per transfer, one bit per clk period.
// Define SPI_MASTER_MSB_FIRST_EN for MSB-first bit order; the default is LSB-first.
module spi_master #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         Reset,
    spi_master_if.master bus
);
    localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSFER = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [0:2]            cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  start_ok;
    logic                  last_bit;

    assign start_ok = bus.Start && (bus.SalveSelect != 2'd3);
    assign last_bit = (cnt_q == LAST_BIT);

    // State register
    always_ff @(posedge clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_ok) state_d = TRANSFER;
            TRANSFER: if (last_bit) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rdata_d = rdata_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        case (state_q)
            IDLE: begin
                cs_d   = 3'b111;
                mosi_d = 1'b0;
                cnt_d  = '0;
                if (start_ok) begin
`ifdef SPI_MASTER_MSB_FIRST_EN
                    mosi_d = bus.MasterDataToSalve[DATA_WIDTH-1];
                    tx_d   = {bus.MasterDataToSalve[DATA_WIDTH-2:0], 1'b0};
`else
                    mosi_d = bus.MasterDataToSalve[0];
                    tx_d   = {1'b0, bus.MasterDataToSalve[DATA_WIDTH-1:1]};
`endif
                    case (bus.SalveSelect)
                        2'd0:    cs_d = 3'b011;
                        2'd1:    cs_d = 3'b101;
                        2'd2:    cs_d = 3'b110;
                        default: cs_d = 3'b111;
                    endcase
                end
            end
            TRANSFER: begin
                if (last_bit) begin
                    rdata_d = rx_q;
                    cs_d    = 3'b111;
                    mosi_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef SPI_MASTER_MSB_FIRST_EN
                    mosi_d = tx_q[DATA_WIDTH-1];
                    tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
`else
                    mosi_d = tx_q[0];
                    tx_d   = {1'b0, tx_q[DATA_WIDTH-1:1]};
`endif
                end
            end
            default: begin
                cs_d   = 3'b111;
                mosi_d = 1'b0;
                cnt_d  = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q   <= '0;
            tx_q    <= '0;
            rdata_q <= '0;
            cs_q    <= 3'b111;
            mosi_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    // Miso is captured mid-bit, on the falling clk edge where Sclk rises
    always_ff @(negedge clk) begin
        if (state_q == TRANSFER) begin
`ifdef SPI_MASTER_MSB_FIRST_EN
            rx_q <= {rx_q[DATA_WIDTH-2:0], bus.Miso};
`else
            rx_q <= {bus.Miso, rx_q[DATA_WIDTH-1:1]};
`endif
        end
    end

    // Sclk is the inverted system clock gated by TRANSFER, giving one pulse per bit
    assign bus.Sclk               = (state_q == TRANSFER) & ~clk;
    assign bus.Cs                 = cs_q;
    assign bus.Mosi               = mosi_q;
    assign bus.MasterDataReceived = rdata_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: scoreboard of tx/rx pairs plus chip-select, reset and restart checks.
module tb_spi_master;
    logic clk = 1'b0;
    logic Reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   sclk_cnt = 0;
    logic [15:0] sb[$];

    spi_master_if #(.DATA_WIDTH(8)) bus_if ();

    spi_master #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge bus_if.Sclk) sclk_cnt <= sclk_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic int bidx(input int i);
`ifdef SPI_MASTER_MSB_FIRST_EN
        return 7 - i;
`else
        return i;
`endif
    endfunction

    // One full transfer: drive Start, feed Miso bit by bit, capture Mosi on falling edges
    task automatic xfer(input logic [1:0] sel, input logic [7:0] tx, input logic [7:0] rx,
                        input logic [2:0] cs_exp);
        logic [7:0]  cap;
        logic [15:0] e;
        int          p0;
        cap = '0;
        @(posedge clk); #1;
        bus_if.Start = 1'b1;
        bus_if.SalveSelect = sel;
        bus_if.MasterDataToSalve = tx;
        sb.push_back({tx, rx});
        @(posedge clk); #1;
        bus_if.Start = 1'b0;
        bus_if.MasterDataToSalve = ~tx;
        bus_if.SalveSelect = 2'd3;
        bus_if.Miso = rx[bidx(0)];
        p0 = sclk_cnt;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            cap[bidx(i)] = bus_if.Mosi;
            if (i == 3) begin
                check("cs_active", 32'(bus_if.Cs), 32'(cs_exp));
                check("sclk_high", 32'(bus_if.Sclk), 32'd1);
            end
            @(posedge clk); #1;
            if (i < 7) bus_if.Miso = rx[bidx(i + 1)];
        end
        e = sb.pop_front();
        check("mosi_word", 32'(cap), 32'(e[15:8]));
        check("rx_word", 32'(bus_if.MasterDataReceived), 32'(e[7:0]));
        check("cs_release", 32'(bus_if.Cs), 32'h7);
        check("sclk_pulses", 32'(sclk_cnt - p0), 32'd8);
    endtask

    logic [7:0] tx_tab [7];
    logic [7:0] rx_tab [7];

    initial begin
        int p0;
        tx_tab = '{8'b01010011, 8'b00111100, 8'b00001001, 8'b00100010,
                   8'b10000011, 8'b00111100, 8'b10011000};
        rx_tab = '{8'b01110011, 8'b00111110, 8'b11001001, 8'b00101010,
                   8'b10011011, 8'b11111100, 8'b10011110};
        Reset = 1'b1;
        bus_if.Start = 1'b0;
        bus_if.SalveSelect = 2'd3;
        bus_if.MasterDataToSalve = '0;
        bus_if.Miso = 1'b0;
        @(posedge clk); #1;
        Reset = 1'b0;
        check("rst_cs", 32'(bus_if.Cs), 32'h7);
        check("rst_mosi", 32'(bus_if.Mosi), 32'd0);
        check("rst_sclk", 32'(bus_if.Sclk), 32'd0);
        check("rst_rdata", 32'(bus_if.MasterDataReceived), 32'd0);
        @(negedge clk); #1;
        check("rst_sclk_low_phase", 32'(bus_if.Sclk), 32'd0);

        // Basic transfer, then seven more back to back
        xfer(2'd1, 8'b01011111, 8'b01010111, 3'b101);
        for (int k = 0; k < 7; k++) xfer(2'd1, tx_tab[k], rx_tab[k], 3'b101);

        xfer(2'd0, 8'hA5, 8'h3C, 3'b011);
        xfer(2'd2, 8'h5A, 8'hC3, 3'b110);

        // Start with no slave selected is ignored
        @(posedge clk); #1;
        bus_if.Start = 1'b1;
        bus_if.SalveSelect = 2'd3;
        p0 = sclk_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("nosel_cs", 32'(bus_if.Cs), 32'h7);
        check("nosel_pulses", 32'(sclk_cnt - p0), 32'd0);
        check("nosel_rdata", 32'(bus_if.MasterDataReceived), 32'hC3);
        bus_if.Start = 1'b0;

        // Reset after four bits aborts without updating the received word
        @(posedge clk); #1;
        bus_if.Start = 1'b1;
        bus_if.SalveSelect = 2'd0;
        bus_if.MasterDataToSalve = 8'hFF;
        bus_if.Miso = 1'b1;
        @(posedge clk); #1;
        bus_if.Start = 1'b0;
        check("abort_cs_before", 32'(bus_if.Cs), 32'h3);
        repeat (4) @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        check("abort_cs", 32'(bus_if.Cs), 32'h7);
        check("abort_mosi", 32'(bus_if.Mosi), 32'd0);
        check("abort_rdata", 32'(bus_if.MasterDataReceived), 32'd0);
        p0 = sclk_cnt;
        repeat (6) @(posedge clk);
        #1;
        check("abort_pulses", 32'(sclk_cnt - p0), 32'd0);
        check("abort_rdata_hold", 32'(bus_if.MasterDataReceived), 32'd0);

        // Start held high: one transfer, one idle cycle, then a restart
        bus_if.Start = 1'b1;
        bus_if.SalveSelect = 2'd2;
        bus_if.MasterDataToSalve = 8'h3C;
        bus_if.Miso = 1'b1;
        @(posedge clk); #1;
        p0 = sclk_cnt;
        check("held_cs_start", 32'(bus_if.Cs), 32'h6);
        repeat (7) @(posedge clk);
        #1;
        check("held_cs_bit7", 32'(bus_if.Cs), 32'h6);
        @(posedge clk); #1;
        check("held_cs_gap", 32'(bus_if.Cs), 32'h7);
        check("held_pulses", 32'(sclk_cnt - p0), 32'd8);
        check("held_rdata", 32'(bus_if.MasterDataReceived), 32'hFF);
        @(posedge clk); #1;
        check("held_restart_cs", 32'(bus_if.Cs), 32'h6);
        bus_if.Start = 1'b0;
        bus_if.Miso = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("held_done_cs", 32'(bus_if.Cs), 32'h7);
        check("held_done_rdata", 32'(bus_if.MasterDataReceived), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
